// File: rtl/conv_encoder.sv
// Programmable rate-1/n convolutional encoder (n = 2..6, memory m = 3..6) with optional
// zero-tail termination and antipodal 4-bit soft lanes for loopback into the decoder.
module conv_encoder #(
  parameter int SOFT_MAG = 7
) (
  input  logic        clk_i,
  input  logic        rst_an_i,
  input  logic        rst_sync_i,
  input  logic        frame_start_i,
  input  logic [1:0]  register_num_i,
  input  logic [2:0]  valid_polynomials_i,
  input  logic [7:0]  polynomial1_i,
  input  logic [7:0]  polynomial2_i,
  input  logic [7:0]  polynomial3_i,
  input  logic [7:0]  polynomial4_i,
  input  logic [7:0]  polynomial5_i,
  input  logic [7:0]  polynomial6_i,
  input  logic        tail_en_i,
  input  logic        data_i,
  input  logic        data_valid_i,
  input  logic        data_last_i,
  output logic        data_ready_o,
  output logic [5:0]  code_o,
  output logic [23:0] soft_data_o,
  output logic        code_valid_o,
  output logic        code_last_o,
  input  logic        code_ready_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        cfg_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL, FLUSH} state_t;

  localparam logic signed [3:0] SOFT_POS = 4'(SOFT_MAG);
  localparam logic signed [3:0] SOFT_NEG = -SOFT_POS;

  state_t      state_q, state_nxt;
  logic [2:0]  m_q;
  logic [6:0]  tap_mask_q;
  logic [5:0]  lane_en_q;
  logic [47:0] poly_q;
  logic        tail_en_q;
  logic [5:0]  hist_q;
  logic [2:0]  cnt_q;
  logic [5:0]  code_q;
  logic        vld_q;
  logic        last_q;
  logic        cfg_err_q;

  logic clr, slot_free, cfg_ok, acc_data, ins_tail, load, in_bit, load_last, beat_done;

  // c_j = parity of the window masked by generator j; only taps 0..m and lanes < n count
  function automatic logic [5:0] encode(input logic [6:0] w, input logic [6:0] mask,
                                        input logic [47:0] polys, input logic [5:0] lane_en);
    logic [5:0] c;
    for (int j = 0; j < 6; j++) begin
      c[j] = lane_en[j] & (^(w & mask & polys[8*j +: 7]));
    end
    return c;
  endfunction

  function automatic logic signed [3:0] soft_lane(input logic bit_i, input logic en);
    if (!en) return 4'sd0;
    return bit_i ? SOFT_NEG : SOFT_POS;
  endfunction

  assign clr       = !rst_an_i || rst_sync_i;
  assign slot_free = !vld_q || code_ready_i;
  assign cfg_ok    = (valid_polynomials_i <= 3'd4);
  assign acc_data  = (state_q == RUN) && data_valid_i && slot_free;
  assign ins_tail  = (state_q == TAIL) && slot_free;
  assign load      = acc_data || ins_tail;
  assign in_bit    = acc_data && data_i;
  assign load_last = (acc_data && data_last_i && !tail_en_q) || (ins_tail && (cnt_q == 3'd1));
  assign beat_done = vld_q && last_q && code_ready_i;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (acc_data && data_last_i) state_nxt = tail_en_q ? TAIL : FLUSH;
      TAIL:    if (ins_tail && (cnt_q == 3'd1)) state_nxt = FLUSH;
      FLUSH:   if (beat_done) state_nxt = IDLE;
      default: state_nxt = state_q;
    endcase
    if (frame_start_i) state_nxt = cfg_ok ? RUN : IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q    <= IDLE;
      m_q        <= 3'd0;
      tap_mask_q <= 7'd0;
      lane_en_q  <= 6'd0;
      poly_q     <= 48'd0;
      tail_en_q  <= 1'b0;
      hist_q     <= 6'd0;
      cnt_q      <= 3'd0;
      code_q     <= 6'd0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cfg_err_q <= frame_start_i && !cfg_ok;
      if (frame_start_i) begin
        m_q        <= 3'd6 - {1'b0, register_num_i};
        tap_mask_q <= 7'h7F >> register_num_i;
        lane_en_q  <= cfg_ok ? (6'h3F >> (3'd4 - valid_polynomials_i)) : 6'd0;
        poly_q     <= {polynomial6_i, polynomial5_i, polynomial4_i,
                       polynomial3_i, polynomial2_i, polynomial1_i};
        tail_en_q  <= tail_en_i;
        hist_q     <= 6'd0;
        cnt_q      <= 3'd0;
        vld_q      <= 1'b0;
        last_q     <= 1'b0;
      end else begin
        // output beat register: load a new codeword or retire the accepted one
        if (load) begin
          code_q <= encode({hist_q, in_bit}, tap_mask_q, poly_q, lane_en_q);
          vld_q  <= 1'b1;
          last_q <= load_last;
          hist_q <= {hist_q[4:0], in_bit};
        end else if (code_ready_i) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end
        if (acc_data && data_last_i && tail_en_q) cnt_q <= m_q;
        else if (ins_tail)                        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  always_comb begin
    soft_data_o = 24'd0;
    for (int j = 0; j < 6; j++) begin
      soft_data_o[4*j +: 4] = soft_lane(code_q[j], lane_en_q[j]);
    end
  end

  assign data_ready_o = (state_q == RUN) && slot_free;
  assign code_o       = code_q;
  assign code_valid_o = vld_q;
  assign code_last_o  = last_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = beat_done;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: impulse responses, no-tail, backpressure,
// rate 1/6, invalid configuration, abort and reset.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst_an_i, rst_sync_i, frame_start_i;
  logic [1:0]  register_num_i;
  logic [2:0]  valid_polynomials_i;
  logic [7:0]  polynomial1_i, polynomial2_i, polynomial3_i;
  logic [7:0]  polynomial4_i, polynomial5_i, polynomial6_i;
  logic        tail_en_i, data_i, data_valid_i, data_last_i, data_ready_o;
  logic [5:0]  code_o;
  logic [23:0] soft_data_o;
  logic        code_valid_o, code_last_o, code_ready_i, busy_o, frame_done_o, cfg_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  int          nb;
  logic [5:0]  b_code [16];
  logic [23:0] b_soft [16];
  logic        b_last [16];
  logic        b_fd   [16];

  always #5 clk = ~clk;

  conv_encoder #(.SOFT_MAG(7)) dut (
    .clk_i(clk), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i), .frame_start_i(frame_start_i),
    .register_num_i(register_num_i), .valid_polynomials_i(valid_polynomials_i),
    .polynomial1_i(polynomial1_i), .polynomial2_i(polynomial2_i), .polynomial3_i(polynomial3_i),
    .polynomial4_i(polynomial4_i), .polynomial5_i(polynomial5_i), .polynomial6_i(polynomial6_i),
    .tail_en_i(tail_en_i), .data_i(data_i), .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .code_o(code_o), .soft_data_o(soft_data_o),
    .code_valid_o(code_valid_o), .code_last_o(code_last_o), .code_ready_i(code_ready_i),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .cfg_err_o(cfg_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] rn, input logic [2:0] vp,
                             input logic [47:0] polys, input logic te);
    register_num_i      = rn;
    valid_polynomials_i = vp;
    {polynomial6_i, polynomial5_i, polynomial4_i,
     polynomial3_i, polynomial2_i, polynomial1_i} = polys;
    tail_en_i     = te;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  // Drives bits[0..nbits-1] and collects beats until code_last_o is accepted.
  task automatic run_frame(input logic [7:0] bits, input int nbits, input bit bp, input int maxc);
    int   idx = 0;
    bit   got_last = 0;
    bit   prev_stall = 0;
    bit   acc;
    logic [5:0] held = '0;
    nb = 0;
    for (int c = 0; c < maxc && !got_last; c++) begin
      code_ready_i = bp ? c[0] : 1'b1;
      if (idx < nbits) begin
        data_valid_i = 1'b1;
        data_i       = bits[idx];
        data_last_i  = (idx == nbits - 1);
      end else begin
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
      end
      #1;
      if (prev_stall) check("hold", {25'd0, code_valid_o, code_o}, {25'd0, 1'b1, held});
      acc = data_valid_i && data_ready_o;
      if (code_valid_o && code_ready_i) begin
        if (nb < 16) begin
          b_code[nb] = code_o;
          b_soft[nb] = soft_data_o;
          b_last[nb] = code_last_o;
          b_fd[nb]   = frame_done_o;
        end
        nb++;
        if (code_last_o) got_last = 1;
      end
      prev_stall = code_valid_o && !code_ready_i;
      if (prev_stall) begin
        held = code_o;
        check("stall_ready", {31'd0, data_ready_o}, 32'd0);
      end
      step();
      if (acc) idx++;
    end
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    code_ready_i = 1'b1;
    if (!got_last) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, code_valid_o}, 32'd0);
    check({tag, "_code"},  {26'd0, code_o}, 32'd0);
    check({tag, "_soft"},  {8'd0, soft_data_o}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    check({tag, "_ready"}, {31'd0, data_ready_o}, 32'd0);
    check({tag, "_last"},  {31'd0, code_last_o}, 32'd0);
    check({tag, "_done"},  {31'd0, frame_done_o}, 32'd0);
    check({tag, "_err"},   {31'd0, cfg_err_o}, 32'd0);
  endtask

  localparam logic [47:0] P_K4  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h0F};
  localparam logic [47:0] P_R16 = {8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  initial begin
    logic [5:0]  exp1 [4];
    logic [23:0] exps [4];
    logic [5:0]  exp4 [7];
    exp1 = '{6'd3, 6'd3, 6'd1, 6'd3};
    exps = '{24'h000099, 24'h000099, 24'h000079, 24'h000099};
    exp4 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00};

    rst_an_i = 1'b0; rst_sync_i = 1'b0; frame_start_i = 1'b0;
    register_num_i = '0; valid_polynomials_i = '0;
    {polynomial6_i, polynomial5_i, polynomial4_i, polynomial3_i, polynomial2_i, polynomial1_i} = '0;
    tail_en_i = 1'b0; data_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0; code_ready_i = 1'b1;
    step(); step();
    check_idle_outputs("reset");
    rst_an_i = 1'b1;
    step();

    // 1: impulse, K=4, with tail
    start_frame(2'b11, 3'd0, P_K4, 1'b1);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    check("t1_ready", {31'd0, data_ready_o}, 32'd1);
    run_frame(8'b1, 1, 0, 20);
    check("t1_nbeats", nb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_code%0d", i), {26'd0, b_code[i]}, {26'd0, exp1[i]});
      check($sformatf("t1_soft%0d", i), {8'd0, b_soft[i]}, {8'd0, exps[i]});
      check($sformatf("t1_last%0d", i), {31'd0, b_last[i]}, {31'd0, i == 3});
      check($sformatf("t1_done%0d", i), {31'd0, b_fd[i]}, {31'd0, i == 3});
    end
    check("t1_busy_end", {31'd0, busy_o}, 32'd0);

    // 2: no tail, data 1,0,1
    start_frame(2'b11, 3'd0, P_K4, 1'b0);
    run_frame(8'b101, 3, 0, 20);
    check("t2_nbeats", nb, 3);
    check("t2_code0", {26'd0, b_code[0]}, 32'd3);
    check("t2_code1", {26'd0, b_code[1]}, 32'd3);
    check("t2_code2", {26'd0, b_code[2]}, 32'd2);
    check("t2_last1", {31'd0, b_last[1]}, 32'd0);
    check("t2_last2", {31'd0, b_last[2]}, 32'd1);
    check("t2_ready_after", {31'd0, data_ready_o}, 32'd0);
    check("t2_busy_after", {31'd0, busy_o}, 32'd0);

    // 3: impulse with alternating backpressure
    start_frame(2'b11, 3'd0, P_K4, 1'b1);
    run_frame(8'b1, 1, 1, 40);
    check("t3_nbeats", nb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_code%0d", i), {26'd0, b_code[i]}, {26'd0, exp1[i]});
      check($sformatf("t3_last%0d", i), {31'd0, b_last[i]}, {31'd0, i == 3});
    end

    // 4: rate 1/6, m=6, impulse with tail
    start_frame(2'b00, 3'd4, P_R16, 1'b1);
    run_frame(8'b1, 1, 0, 30);
    check("t4_nbeats", nb, 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t4_code%0d", i), {26'd0, b_code[i]}, {26'd0, exp4[i]});
    check("t4_soft0", {8'd0, b_soft[0]}, 32'h00777779);
    check("t4_last6", {31'd0, b_last[6]}, 32'd1);

    // 5: invalid configuration
    start_frame(2'b11, 3'd5, P_K4, 1'b1);
    check("t5_err", {31'd0, cfg_err_o}, 32'd1);
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    check("t5_ready", {31'd0, data_ready_o}, 32'd0);
    data_valid_i = 1'b1; data_i = 1'b1;
    step();
    check("t5_err_pulse", {31'd0, cfg_err_o}, 32'd0);
    check("t5_busy2", {31'd0, busy_o}, 32'd0);
    check("t5_no_beat", {31'd0, code_valid_o}, 32'd0);
    data_valid_i = 1'b0; data_i = 1'b0;

    // 6a: abort mid-TAIL with a stalled beat, then new frame from zero history
    start_frame(2'b11, 3'd0, P_K4, 1'b1);
    code_ready_i = 1'b0;
    data_valid_i = 1'b1; data_i = 1'b1; data_last_i = 1'b1;
    step();
    data_valid_i = 1'b0; data_i = 1'b0; data_last_i = 1'b0;
    step();
    check("t6_stalled", {31'd0, code_valid_o}, 32'd1);
    start_frame(2'b11, 3'd0, P_K4, 1'b0);
    check("t6_dropped", {31'd0, code_valid_o}, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd1);
    run_frame(8'b10, 2, 0, 20);
    check("t6_nbeats", nb, 2);
    check("t6_code0", {26'd0, b_code[0]}, 32'd0);
    check("t6_code1", {26'd0, b_code[1]}, 32'd3);

    // 6b: rst_an_i low for one cycle mid-frame
    start_frame(2'b11, 3'd0, P_K4, 1'b1);
    code_ready_i = 1'b0;
    data_valid_i = 1'b1; data_i = 1'b1; data_last_i = 1'b1;
    step();
    data_valid_i = 1'b0; data_i = 1'b0; data_last_i = 1'b0;
    check("t6b_pre_valid", {31'd0, code_valid_o}, 32'd1);
    rst_an_i = 1'b0;
    step();
    rst_an_i = 1'b1;
    check_idle_outputs("t6b_rst");

    // 6c: rst_sync_i has the same effect
    start_frame(2'b11, 3'd0, P_K4, 1'b1);
    data_valid_i = 1'b1; data_i = 1'b1; data_last_i = 1'b1;
    step();
    data_valid_i = 1'b0; data_i = 1'b0; data_last_i = 1'b0;
    rst_sync_i = 1'b1;
    step();
    rst_sync_i = 1'b0;
    code_ready_i = 1'b1;
    check_idle_outputs("t6c_sync");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Programmable rate-1/n convolutional encoder: the transmit-side counterpart of the Viterbi decoder's branch metric unit.
- Uses the same configuration fields: register_num, valid_polynomials, polynomial1..6.
- Encodes a serial info-bit stream into n-bit codewords, with optional zero-tail termination.
- Also emits each codeword as antipodal 4-bit soft lanes in the decoder's soft_data format, so the encoder can loop straight back into the decoder for verification.

Parameters:
- SOFT_MAG, 7, magnitude of the antipodal soft value (4-bit signed, 1..7).

Ports:
- clk_i  in  1  clock.
- rst_an_i  in  1  synchronous active-low reset.
- rst_sync_i  in  1  synchronous active-high soft clear; same effect as reset.
- frame_start_i  in  1  pulse; latches configuration and starts a frame.
- register_num_i  in  2  memory depth m: 00->6, 01->5, 10->4, 11->3.
- valid_polynomials_i  in  3  n = value+2 (0..4 -> n = 2..6); 5..7 invalid.
- polynomial1_i..polynomial6_i  in  8 each  generator taps; bit k taps the input delayed k cycles; bits above m ignored.
- tail_en_i  in  1  sampled at frame_start_i; 1 = append m zero tail bits.
- data_i  in  1  info bit.
- data_valid_i  in  1  info bit valid.
- data_last_i  in  1  marks last info bit of the frame.
- data_ready_o  out  1  encoder accepts data this cycle.
- code_o  out  6  codeword; bit j = generator j+1; bits >= n are 0.
- soft_data_o  out  24  lane j = [4j+3:4j]; code bit 0 -> +SOFT_MAG, code bit 1 -> -SOFT_MAG; lanes >= n are 0.
- code_valid_o  out  1  output beat valid.
- code_last_o  out  1  final beat of the frame.
- code_ready_i  in  1  downstream accepts the beat.
- busy_o  out  1  frame in progress (state != IDLE).
- frame_done_o  out  1  one-cycle pulse when the last beat is accepted.
- cfg_err_o  out  1  one-cycle pulse on frame_start_i with an invalid valid_polynomials_i.

Behaviour:
- Reset (rst_an_i low or rst_sync_i high, highest priority): all outputs 0, shift register cleared, state IDLE.
- Configuration is captured only on frame_start_i; inputs may change freely afterwards.
- States:
  - IDLE: waits for frame_start_i.
  - RUN: accepts info bits.
  - TAIL: injects zero bits.
  - FLUSH: waits for the last beat to be accepted, then returns to IDLE.
- frame_start_i in any state:
  - Clears the shift register and drops any pending output beat (code_valid_o -> 0).
  - Latches configuration.
  - Valid config -> next state RUN. Invalid config (5..7) -> cfg_err_o = 1 and next state IDLE.
- Window: w[0] = current bit, w[k] = bit accepted k steps earlier (k = 1..m); history is reset to 0 at frame start.
- Codeword: c_j = XOR over k = 0..m of (poly_j[k] & w[k]).
- data_ready_o = (state == RUN) & (!code_valid_o | code_ready_i).
- Input is accepted on data_valid_i & data_ready_o. The output beat is registered, so latency is 1 cycle: code_valid_o is high the cycle after acceptance.
- The output beat holds stable while code_valid_o & !code_ready_i. A new beat may load in the same cycle the old one is accepted, giving full throughput of 1 bit/cycle.
- Accepted bit with data_last_i:
  - tail_en = 1 -> go to TAIL; the tail counter loads m.
  - tail_en = 0 -> that beat carries code_last_o = 1; go to FLUSH.
- TAIL: inserts bit 0 whenever the output slot is free, under the same rule as data_ready_o. The counter decrements per inserted bit. The m-th tail beat carries code_last_o; then go to FLUSH.
- frame_done_o pulses on the cycle code_valid_o & code_last_o & code_ready_i.
- data_valid_i outside RUN is ignored; no bit is consumed.
- Soft lanes are computed combinationally from the registered code bits. Soft encoding: +7 = 4'h7, -7 = 4'h9.

Test Plan:
1. Impulse, K=4: register_num=11, valid_polynomials=000, poly1=0x0F, poly2=0x0B, tail_en=1; send data 1 with data_last_i, code_ready_i held 1.
   -> Exactly 4 beats: code_o = 3, 3, 1, 3.
   -> soft_data_o = 0x000099, 0x000099, 0x000079, 0x000099.
   -> code_last_o on beat 4; frame_done_o on that cycle.
2. No tail: same config, tail_en=0, data 1,0,1 (last on the third bit).
   -> code_o = 3, 3, 2.
   -> code_last_o on the third beat; data_ready_o is 0 afterwards.
3. Backpressure: scenario 1 with code_ready_i low on alternate cycles.
   -> Beats are identical and in the same order; each beat is held stable while stalled; no bit is lost or duplicated; data_ready_o is 0 while stalled.
4. Rate 1/6, m=6: valid_polynomials=100, register_num=00, poly1..6 = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20; impulse with tail.
   -> 7 beats: code_o = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x00.
5. Invalid config: frame_start_i with valid_polynomials=101.
   -> cfg_err_o pulse; busy_o stays 0; data_ready_o stays 0.
6. Abort and reset: frame_start_i mid-TAIL with one beat stalled.
   -> code_valid_o is 0 the next cycle, and the new frame starts from a zero history.
   -> Separately, driving rst_an_i low for one cycle mid-frame zeroes all outputs and returns to IDLE.
